apb_slot_bridge: RTL and testbench

// Single-clock APB bridge with parametrised slot decode: one upstream APB master port fans out to up to 16 downstream APB slaves.

---
 rtl/apb_slot_bridge_if.sv | 39 +++
 rtl/apb_slot_bridge.sv | 194 +++++++++++++++++++
 tb/tb_apb_slot_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slot_bridge_if.sv
// apb_slot_bridge_if: APB bus bundle with NS select/response lanes.
// master: PSEL/PADDR/PWRITE/PENABLE/PWDATA out, PRDATA/PREADY/PSLVERR in.
// slave:  the reverse. NS=1 for the upstream port, NS=slots for fan-out.
interface apb_slot_bridge_if #(
   parameter int NS = 1,
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [NS-1:0]    PSEL;
   logic [AW-1:0]    PADDR;
   logic             PWRITE;
   logic             PENABLE;
   logic [DW-1:0]    PWDATA;
   logic [NS*DW-1:0] PRDATA;
   logic [NS-1:0]    PREADY;
   logic [NS-1:0]    PSLVERR;

   modport master (
      output PSEL,
      output PADDR,
      output PWRITE,
      output PENABLE,
      output PWDATA,
      input  PRDATA,
      input  PREADY,
      input  PSLVERR
   );

   modport slave (
      input  PSEL,
      input  PADDR,
      input  PWRITE,
      input  PENABLE,
      input  PWDATA,
      output PRDATA,
      output PREADY,
      output PSLVERR
   );
endinterface

// File: rtl/apb_slot_bridge.sv
// apb_slot_bridge: re-timing APB bridge, one master to NUM_SLOTS slots.
// Ports: PCLK, PRESETN (async, active low); pm = upstream APB (slave
// side, NS=1); sc = slot APB (master side, NS=NUM_SLOTS, one-hot PSEL);
// TIMEOUT_EVT / UNMAPPED_EVT = one-cycle abort/decode-miss pulses.
module apb_slot_bridge #(
   parameter int          NUM_SLOTS      = 16,
   parameter int          ADDR_WIDTH     = 32,
   parameter int          DATA_WIDTH     = 32,
   parameter int          SLOT_LSB       = 24,
   parameter logic [15:0] SLOT_MASK      = 16'hFFFF,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   apb_slot_bridge_if.slave  pm,
   apb_slot_bridge_if.master sc,
   output logic              TIMEOUT_EVT,
   output logic              UNMAPPED_EVT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   // Counter only has to reach TIMEOUT_CYCLES-1; it saturates at
   // all-ones, which also covers the disabled (0) case.
   localparam int CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0] CNT_LAST =
      TO_EN ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b1}};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   state_t                  state;
   logic                    armed;
   logic [3:0]              idx;
   logic [CW-1:0]           cnt;

   logic [NUM_SLOTS-1:0]    psel_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic                    pwrite_q;
   logic                    penable_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [DATA_WIDTH-1:0]   prdata_q;
   logic                    pready_q;
   logic                    pslverr_q;
   logic                    to_q;
   logic                    un_q;

   logic [3:0]              req_idx;
   logic                    req_map;
   logic                    go;
   logic [NUM_SLOTS-1:0]    req_oh;
   logic                    s_rdy;
   logic                    s_err;
   logic [DATA_WIDTH-1:0]   s_rdata;

   assign req_idx = pm.PADDR[SLOT_LSB+3:SLOT_LSB];
   assign req_map = ({1'b0, req_idx} < 5'(NUM_SLOTS))
                  && SLOT_MASK[req_idx];

   // armed guards against a PENABLE_PM left high across a completed
   // transfer or a reset being taken as a fresh access phase.
   assign go = (state == S_IDLE) && armed
             && pm.PSEL[0] && pm.PENABLE;

   always_comb begin
      req_oh = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         req_oh[i] = (req_idx == 4'(i));
      end
   end

   // Response lane of the captured slot; other slots are don't-care.
   always_comb begin
      s_rdy   = 1'b0;
      s_err   = 1'b0;
      s_rdata = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (idx == 4'(i)) begin
            s_rdy   = sc.PREADY[i];
            s_err   = sc.PSLVERR[i];
            s_rdata = sc.PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state     <= S_IDLE;
         armed     <= 1'b0;
         idx       <= '0;
         cnt       <= '0;
         psel_q    <= '0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         penable_q <= 1'b0;
         pwdata_q  <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         to_q      <= 1'b0;
         un_q      <= 1'b0;
      end else begin
         pready_q <= 1'b0;
         to_q     <= 1'b0;
         un_q     <= 1'b0;

         if (go) begin
            armed <= 1'b0;
         end else if (!pm.PENABLE) begin
            armed <= 1'b1;
         end

         unique case (state)
            S_IDLE: begin
               if (go) begin
                  idx <= req_idx;
                  if (req_map) begin
                     state     <= S_SETUP;
                     psel_q    <= req_oh;
                     penable_q <= 1'b0;
                     paddr_q   <= pm.PADDR;
                     pwdata_q  <= pm.PWDATA;
                     pwrite_q  <= pm.PWRITE;
                     cnt       <= '0;
                  end else begin
                     state     <= S_RESP;
                     pready_q  <= 1'b1;
                     prdata_q  <= '0;
                     pslverr_q <= 1'b1;
                     un_q      <= 1'b1;
                  end
               end
            end

            S_SETUP: begin
               state     <= S_ACCESS;
               penable_q <= 1'b1;
            end

            S_ACCESS: begin
               if (s_rdy) begin
                  state     <= S_RESP;
                  pready_q  <= 1'b1;
                  prdata_q  <= s_rdata;
                  pslverr_q <= s_err;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  paddr_q   <= '0;
                  pwdata_q  <= '0;
                  pwrite_q  <= 1'b0;
               end else if (TO_EN && cnt == CNT_LAST) begin
                  state     <= S_RESP;
                  pready_q  <= 1'b1;
                  prdata_q  <= '0;
                  pslverr_q <= 1'b1;
                  to_q      <= 1'b1;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  paddr_q   <= '0;
                  pwdata_q  <= '0;
                  pwrite_q  <= 1'b0;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_RESP: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign sc.PSEL       = psel_q;
   assign sc.PADDR      = paddr_q;
   assign sc.PWRITE     = pwrite_q;
   assign sc.PENABLE    = penable_q;
   assign sc.PWDATA     = pwdata_q;
   assign pm.PRDATA     = prdata_q;
   assign pm.PREADY     = pready_q;
   assign pm.PSLVERR    = pslverr_q;
   assign TIMEOUT_EVT   = to_q;
   assign UNMAPPED_EVT  = un_q;

endmodule

// File: tb/tb_apb_slot_bridge.sv
// tb_apb_slot_bridge: vector table + scoreboard bench for the bridge.
// 8 slots, slot 6 masked, 8-cycle timeout; slot models in the bench.
module tb_apb_slot_bridge;

   localparam int          NS   = 8;
   localparam int          AW   = 32;
   localparam int          DW   = 32;
   localparam int          LSB  = 24;
   localparam logic [15:0] MASK = 16'h00BF;
   localparam int          TO   = 8;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          wr;
      logic [7:0]    wt;
      logic [DW-1:0] srd;
      logic          serr;
      logic          nz;
      logic [DW-1:0] e_rd;
      logic          e_err;
      logic          e_to;
      logic          e_un;
      int            e_lat;
      logic [NS-1:0] e_psel;
      int            e_en;
   } vec_t;

   typedef struct {
      logic [DW-1:0] rd;
      logic          err;
      logic          to;
      logic          un;
   } resp_t;

   logic PCLK    = 1'b0;
   logic PRESETN = 1'b0;
   logic TIMEOUT_EVT;
   logic UNMAPPED_EVT;

   always #5 PCLK = ~PCLK;

   apb_slot_bridge_if #(.NS(1),  .AW(AW), .DW(DW)) pm();
   apb_slot_bridge_if #(.NS(NS), .AW(AW), .DW(DW)) sc();

   apb_slot_bridge #(
      .NUM_SLOTS      (NS),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .SLOT_LSB       (LSB),
      .SLOT_MASK      (MASK),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .PCLK         (PCLK),
      .PRESETN      (PRESETN),
      .pm           (pm),
      .sc           (sc),
      .TIMEOUT_EVT  (TIMEOUT_EVT),
      .UNMAPPED_EVT (UNMAPPED_EVT)
   );

   // Slot models: ready after wt[i] access cycles (8'hFF = never).
   logic [7:0]    wait_st [NS];
   logic [DW-1:0] rd      [NS];
   logic [NS-1:0] err_v;
   logic          noise;
   int            acc;

   always @(posedge PCLK) acc <= sc.PENABLE ? acc + 1 : 0;

   always_comb begin
      sc.PRDATA  = '0;
      sc.PREADY  = '0;
      sc.PSLVERR = '0;
      for (int i = 0; i < NS; i++) begin
         sc.PRDATA[i*DW +: DW] = rd[i];
         if (sc.PSEL[i]) begin
            sc.PREADY[i]  = sc.PENABLE && (acc >= int'(wait_st[i]));
            sc.PSLVERR[i] = err_v[i];
         end else begin
            sc.PREADY[i]  = noise;
            sc.PSLVERR[i] = noise;
         end
      end
   end

   // Bus monitor, sampled on the falling edge.
   int            psel_cyc, en_cyc, rdy_cnt, to_cnt, un_cnt, bad;
   logic [NS-1:0] last_psel;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_wdata;
   logic          last_wr;

   always @(negedge PCLK) begin
      if (sc.PSEL != '0) begin
         psel_cyc++;
         last_psel = sc.PSEL;
         if (!$onehot(sc.PSEL)) bad++;
      end
      if (sc.PENABLE) begin
         en_cyc++;
         last_addr  = sc.PADDR;
         last_wdata = sc.PWDATA;
         last_wr    = sc.PWRITE;
         if (sc.PSEL == '0) bad++;
      end
      if (pm.PREADY[0]) rdy_cnt++;
      if (TIMEOUT_EVT)  to_cnt++;
      if (UNMAPPED_EVT) un_cnt++;
   end

   int    n_tests;
   int    n_fail;
   resp_t sb[$];
   vec_t  vt[10];
   vec_t  bb[3];
   vec_t  rv;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic run(input string tag, input vec_t v);
      int    s, lat, p0, e0, r0, t0, u0, pexp;
      bit    done;
      resp_t e;
      s = int'(v.addr[LSB+3:LSB]);
      if (s < NS) begin
         wait_st[s] = v.wt;
         rd[s]      = v.srd;
         err_v[s]   = v.serr;
      end
      noise      = v.nz;
      pm.PSEL    = 1'b1;
      pm.PADDR   = v.addr;
      pm.PWDATA  = v.wdata;
      pm.PWRITE  = v.wr;
      pm.PENABLE = 1'b0;
      p0 = psel_cyc; e0 = en_cyc; r0 = rdy_cnt;
      t0 = to_cnt;   u0 = un_cnt;
      @(posedge PCLK); #1;
      sb.push_back('{v.e_rd, v.e_err, v.e_to, v.e_un});
      pm.PENABLE = 1'b1;
      lat  = 1;
      done = 1'b0;
      while (!done && lat < 40) begin
         @(posedge PCLK); #1;
         lat++;
         done = pm.PREADY[0];
      end
      chk({tag, ".ready"}, 64'(done), 64'(1));
      chk({tag, ".lat"}, 64'(lat), 64'(v.e_lat));
      e = sb.pop_front();
      chk({tag, ".rdata"}, 64'(pm.PRDATA), 64'(e.rd));
      chk({tag, ".err"}, 64'(pm.PSLVERR[0]), 64'(e.err));
      chk({tag, ".to_evt"}, 64'(TIMEOUT_EVT), 64'(e.to));
      chk({tag, ".un_evt"}, 64'(UNMAPPED_EVT), 64'(e.un));
      chk({tag, ".sc_clr"},
          64'({sc.PSEL, sc.PENABLE, sc.PWRITE, sc.PADDR}),
          64'(0));
      chk({tag, ".sc_wd"}, 64'(sc.PWDATA), 64'(0));
      @(posedge PCLK); #1;
      pm.PSEL    = 1'b0;
      pm.PENABLE = 1'b0;
      chk({tag, ".pulse"}, 64'(pm.PREADY[0]), 64'(0));
      chk({tag, ".held"}, 64'(pm.PRDATA), 64'(e.rd));
      chk({tag, ".nrdy"}, 64'(rdy_cnt - r0), 64'(1));
      chk({tag, ".nto"}, 64'(to_cnt - t0), 64'(v.e_to));
      chk({tag, ".nun"}, 64'(un_cnt - u0), 64'(v.e_un));
      pexp = (v.e_en == 0) ? 0 : v.e_en + 1;
      chk({tag, ".psel_cyc"}, 64'(psel_cyc - p0), 64'(pexp));
      chk({tag, ".en_cyc"}, 64'(en_cyc - e0), 64'(v.e_en));
      if (v.e_en > 0) begin
         chk({tag, ".psel"}, 64'(last_psel), 64'(v.e_psel));
         chk({tag, ".paddr"}, 64'(last_addr), 64'(v.addr));
         chk({tag, ".pwdata"}, 64'(last_wdata), 64'(v.wdata));
         chk({tag, ".pwrite"}, 64'(last_wr), 64'(v.wr));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p0, r0, n;
      n_tests = 0;
      n_fail  = 0;
      noise   = 1'b0;
      err_v   = '0;
      for (int i = 0; i < NS; i++) begin
         wait_st[i] = 8'd0;
         rd[i]      = 32'hD000_0000 | 32'(i);
      end
      pm.PSEL    = 1'b0;
      pm.PADDR   = '0;
      pm.PWDATA  = '0;
      pm.PWRITE  = 1'b0;
      pm.PENABLE = 1'b0;

      // addr, wdata, wr, wt, srd, serr, nz,
      // e_rd, e_err, e_to, e_un, e_lat, e_psel, e_en
      vt[0] = '{32'h0300_0010, 32'hA5A5_0001, 1'b1, 8'd0,
                32'h0000_0033, 1'b0, 1'b0,
                32'h0000_0033, 1'b0, 1'b0, 1'b0, 4, 8'h08, 1};
      vt[1] = '{32'h0500_0020, 32'h0, 1'b0, 8'd3,
                32'h1234_5678, 1'b0, 1'b0,
                32'h1234_5678, 1'b0, 1'b0, 1'b0, 7, 8'h20, 4};
      vt[2] = '{32'h0900_0000, 32'h0, 1'b0, 8'd0,
                32'h0, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b0, 1'b1, 2, 8'h00, 0};
      vt[3] = '{32'h0600_0004, 32'h1111_2222, 1'b1, 8'd0,
                32'h6666_6666, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b0, 1'b1, 2, 8'h00, 0};
      vt[4] = '{32'h0700_0008, 32'h0, 1'b0, 8'd1,
                32'hCAFE_F00D, 1'b1, 1'b1,
                32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 5, 8'h80, 2};
      vt[5] = '{32'h0000_0040, 32'h0, 1'b0, 8'hFF,
                32'h0BAD_0BAD, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b1, 1'b0, 11, 8'h01, 8};
      vt[6] = '{32'h0000_0044, 32'h5A5A_5A5A, 1'b1, 8'd0,
                32'h0000_0001, 1'b0, 1'b1,
                32'h0000_0001, 1'b0, 1'b0, 1'b0, 4, 8'h01, 1};
      vt[7] = '{32'hF2AB_CDE0, 32'hDEAD_BEEF, 1'b1, 8'd2,
                32'h2222_0002, 1'b0, 1'b1,
                32'h2222_0002, 1'b0, 1'b0, 1'b0, 6, 8'h04, 3};
      vt[8] = '{32'h0F00_0000, 32'h0, 1'b0, 8'd0,
                32'h0, 1'b0, 1'b0,
                32'h0, 1'b1, 1'b0, 1'b1, 2, 8'h00, 0};
      vt[9] = '{32'h0400_0100, 32'h0, 1'b0, 8'd0,
                32'h4444_4444, 1'b0, 1'b1,
                32'h4444_4444, 1'b0, 1'b0, 1'b0, 4, 8'h10, 1};

      bb[0] = '{32'h0100_0004, 32'h0, 1'b0, 8'd0,
                32'h1111_0001, 1'b0, 1'b0,
                32'h1111_0001, 1'b0, 1'b0, 1'b0, 4, 8'h02, 1};
      bb[1] = '{32'h0200_0008, 32'h7777_0008, 1'b1, 8'd1,
                32'h2222_0002, 1'b0, 1'b1,
                32'h2222_0002, 1'b0, 1'b0, 1'b0, 5, 8'h04, 2};
      bb[2] = '{32'h0100_000C, 32'h0, 1'b0, 8'd2,
                32'h1111_0003, 1'b0, 1'b0,
                32'h1111_0003, 1'b0, 1'b0, 1'b0, 6, 8'h02, 3};
      rv    = '{32'h0100_0000, 32'h0, 1'b0, 8'd0,
                32'h0101_0101, 1'b0, 1'b0,
                32'h0101_0101, 1'b0, 1'b0, 1'b0, 4, 8'h02, 1};

      // Reset state.
      repeat (2) @(posedge PCLK);
      #1;
      chk("rst.ctl",
          64'({sc.PSEL, sc.PENABLE, sc.PWRITE, pm.PREADY,
               pm.PSLVERR, TIMEOUT_EVT, UNMAPPED_EVT}),
          64'(0));
      chk("rst.addr", 64'(sc.PADDR), 64'(0));
      chk("rst.wd", 64'(sc.PWDATA), 64'(0));
      chk("rst.rd", 64'(pm.PRDATA), 64'(0));
      PRESETN = 1'b1;
      @(posedge PCLK); #1;

      for (int i = 0; i < 10; i++) begin
         run($sformatf("v%0d", i), vt[i]);
      end

      // Reset in the middle of a slot access that never completes.
      wait_st[1] = 8'hFF;
      noise      = 1'b0;
      pm.PSEL    = 1'b1;
      pm.PADDR   = 32'h0100_0000;
      pm.PWRITE  = 1'b1;
      pm.PWDATA  = 32'h3333_3333;
      pm.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      pm.PENABLE = 1'b1;
      n = 0;
      while (!sc.PENABLE && n < 10) begin
         @(posedge PCLK); #1;
         n++;
      end
      chk("mrst.en_seen", 64'(sc.PENABLE), 64'(1));
      #2;
      PRESETN = 1'b0;
      #1;
      chk("mrst.ctl",
          64'({sc.PSEL, sc.PENABLE, sc.PWRITE, pm.PREADY,
               pm.PSLVERR, TIMEOUT_EVT, UNMAPPED_EVT}),
          64'(0));
      chk("mrst.addr", 64'(sc.PADDR), 64'(0));
      chk("mrst.wd", 64'(sc.PWDATA), 64'(0));
      chk("mrst.rd", 64'(pm.PRDATA), 64'(0));
      @(posedge PCLK); #1;
      PRESETN = 1'b1;
      p0 = psel_cyc;
      r0 = rdy_cnt;
      repeat (5) @(posedge PCLK);
      #1;
      chk("mrst.no_sel", 64'(psel_cyc - p0), 64'(0));
      chk("mrst.no_rdy", 64'(rdy_cnt - r0), 64'(0));
      run("mrst.recover", rv);

      // Back-to-back transfers: slots 1, 2, 1.
      r0 = rdy_cnt;
      for (int i = 0; i < 3; i++) begin
         run($sformatf("b2b%0d", i), bb[i]);
      end
      chk("b2b.pulses", 64'(rdy_cnt - r0), 64'(3));

      chk("sb.empty", 64'(sb.size()), 64'(0));
      chk("proto", 64'(bad), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
